// File: rtl/mul_div_32bit_pkg.sv
// mul_div_32bit_pkg: shared op/state encodings and iteration constants for the multiply/divide unit
package mul_div_32bit_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_MADD  = 3'b010,
    OP_MSUB  = 3'b011,
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;
  localparam int ITERS = 32;
  localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);
  function automatic logic op_signed(op_e o);
    return o == OP_MULT || o == OP_MADD || o == OP_MSUB || o == OP_DIV;
  endfunction
  function automatic logic op_div(op_e o);
    return o == OP_DIV || o == OP_DIVU;
  endfunction
  function automatic logic op_move(op_e o);
    return o == OP_MTHI || o == OP_MTLO;
  endfunction
endpackage

// File: rtl/mul_div_fsm.sv
// mul_div_fsm: sequencing state, iteration counter and busy/done flags
module mul_div_fsm
  import mul_div_32bit_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   move,
  input  logic   dz,
  output state_e state,
  output logic   busy,
  output logic   done
);
  state_e     nxt;
  logic [5:0] cnt, cnt_nxt;
  // next state: moves never leave idle, divide-by-zero skips the iterations
  always_comb begin
    nxt = state;
    cnt_nxt = 6'd0;
    case (state)
      S_IDLE: nxt = (start && !move) ? (dz ? S_FIX : S_CALC) : S_IDLE;
      S_CALC: begin
        nxt = (cnt == LAST_ITER) ? S_FIX : S_CALC;
        cnt_nxt = (cnt == LAST_ITER) ? 6'd0 : cnt + 6'd1;
      end
      S_FIX:  nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  // state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= 6'd0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
    end
  end
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
endmodule

// File: rtl/mul_div_32bit.sv
// mul_div_32bit: iterative 32-bit multiply/divide unit with HI/LO result registers
module mul_div_32bit
  import mul_div_32bit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_e      state;
  op_e         op_i, op_q;
  logic        sg, div_i, dz, accept, div_q, pneg, rneg, dz_q, ok;
  logic [31:0] ma, mb, md, x, q, r;
  logic [32:0] sum;
  logic [63:0] rp, rp_step, prod, fix_val;
  assign op_i = op_e'(op);
  assign sg = op_signed(op_i);
  assign div_i = op_div(op_i);
  assign dz = div_i && b == 32'd0;
  assign accept = state == S_IDLE && start;
  assign ma = (sg && a[31]) ? -a : a;
  assign mb = (sg && b[31]) ? -b : b;
  mul_div_fsm u_fsm (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .move  (op_move(op_i)),
    .dz    (dz),
    .state (state),
    .busy  (busy),
    .done  (done)
  );
  // one shared adder: add multiplicand for multiply, trial-subtract divisor for divide
  always_comb begin
    div_q = op_div(op_q);
    x = div_q ? rp[62:31] : rp[63:32];
    sum = {1'b0, x} + {1'b0, div_q ? ~md : md} + 33'(div_q);
    ok = rp[63] | sum[32];
    rp_step = div_q ? (ok ? {sum[31:0], rp[30:0], 1'b1} : {rp[62:0], 1'b0})
                    : (rp[0] ? {sum, rp[31:1]} : {1'b0, rp[63:1]});
  end
  // sign restoration and accumulate applied in the fix cycle
  always_comb begin
    prod = pneg ? -rp : rp;
    q = pneg ? -rp[31:0] : rp[31:0];
    r = rneg ? -rp[63:32] : rp[63:32];
    fix_val = dz_q ? rp
            : div_q ? {r, q}
            : op_q == OP_MADD ? {hi, lo} + prod
            : op_q == OP_MSUB ? {hi, lo} - prod
            : prod;
  end
  // operand capture, iteration register and HI/LO updates
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
      rp <= 64'd0;
      md <= 32'd0;
      op_q <= OP_MULT;
      pneg <= 1'b0;
      rneg <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op_i;
        pneg <= sg && (a[31] ^ b[31]);
        rneg <= sg && a[31];
        dz_q <= dz;
        md <= div_i ? mb : ma;
        rp <= dz ? {a, 32'hFFFF_FFFF} : div_i ? {32'd0, ma} : {32'd0, mb};
        if (op_i == OP_MTHI) hi <= a;
        if (op_i == OP_MTLO) lo <= a;
      end
      if (state == S_CALC) rp <= rp_step;
      if (state == S_FIX) {hi, lo} <= fix_val;
    end
  end
endmodule

// File: tb/tb_mul_div_32bit.sv
// tb_mul_div_32bit: directed self-checking bench for the multiply/divide unit
module tb_mul_div_32bit;
  import mul_div_32bit_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int npass = 0;
  int ntotal = 0;
  always #5 clk = ~clk;
  mul_div_32bit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc);
    issue(o, x, y);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'hAAAA;
    repeat (2) @(negedge clk);
    start = 1'b0; reset = 1'b0;
    ntotal++;
    if ({busy, done, hi, lo} !== 66'd0) $display("FAIL reset got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
    else npass++;
  endtask
  task automatic test_multu;
    int errs = 0;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 1; c <= 34; c++) begin
      if (busy !== 1'b1 || done !== (c == 34) || (c <= 33 && {hi, lo} !== 64'd0)) errs++;
      if (c < 34) @(negedge clk);
    end
    ntotal++;
    if (errs !== 0) $display("FAIL multu_window got %0d bad cycles want 0", errs);
    else npass++;
    ntotal++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_result got %h_%h want fffffffe_00000001", hi, lo);
    else npass++;
    @(negedge clk);
    ntotal++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL multu_idle got busy=%b done=%b want 0 0", busy, done);
    else npass++;
  endtask
  task automatic test_madd_msub;
    int cyc;
    run_op(OP_MULT, -32'sd3, 32'd7, cyc);
    ntotal++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB || cyc !== 34) $display("FAIL mult got %h_%h cyc=%0d want ffffffff_ffffffeb cyc=34", hi, lo, cyc);
    else npass++;
    run_op(OP_MADD, 32'd5, 32'd4, cyc);
    ntotal++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL madd got %h_%h want ffffffff_ffffffff", hi, lo);
    else npass++;
    run_op(OP_MSUB, 32'd1, 32'd1, cyc);
    ntotal++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL msub got %h_%h want ffffffff_fffffffe", hi, lo);
    else npass++;
    @(negedge clk);
  endtask
  task automatic test_div;
    int cyc;
    run_op(OP_DIV, -32'sd7, 32'd2, cyc);
    ntotal++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD || cyc !== 34) $display("FAIL div_neg got hi=%h lo=%h cyc=%0d want ffffffff fffffffd 34", hi, lo, cyc);
    else npass++;
    @(negedge clk);
    run_op(OP_DIVU, 32'd100, 32'd7, cyc);
    ntotal++;
    if (hi !== 32'd2 || lo !== 32'd14) $display("FAIL divu got hi=%0d lo=%0d want 2 14", hi, lo);
    else npass++;
    @(negedge clk);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    ntotal++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) $display("FAIL div_wrap got hi=%h lo=%h want 00000000 80000000", hi, lo);
    else npass++;
    @(negedge clk);
    run_op(OP_DIV, 32'd7, -32'sd2, cyc);
    ntotal++;
    if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) $display("FAIL div_negb got hi=%h lo=%h want 00000001 fffffffd", hi, lo);
    else npass++;
    @(negedge clk);
  endtask
  task automatic test_div0;
    int cyc;
    run_op(OP_DIVU, 32'h1234, 32'd0, cyc);
    ntotal++;
    if (cyc !== 2 || hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) $display("FAIL div0 got cyc=%0d hi=%h lo=%h want 2 00001234 ffffffff", cyc, hi, lo);
    else npass++;
    @(negedge clk);
  endtask
  task automatic test_move;
    issue(OP_MTHI, 32'hDEAD, 32'd0);
    ntotal++;
    if (hi !== 32'hDEAD || busy !== 1'b0 || done !== 1'b0) $display("FAIL mthi got hi=%h busy=%b done=%b want 0000dead 0 0", hi, busy, done);
    else npass++;
    issue(OP_MTLO, 32'hBEEF, 32'd0);
    ntotal++;
    if (lo !== 32'hBEEF || hi !== 32'hDEAD || busy !== 1'b0) $display("FAIL mtlo got hi=%h lo=%h busy=%b want 0000dead 0000beef 0", hi, lo, busy);
    else npass++;
  endtask
  task automatic test_back_to_back;
    int cyc;
    run_op(OP_MULTU, 32'd3, 32'd5, cyc);
    start = 1'b1; op = OP_MTLO; a = 32'h55;
    @(negedge clk);
    ntotal++;
    if (lo !== 32'd15 || busy !== 1'b0) $display("FAIL done_start_ignored got lo=%h busy=%b want 0000000f 0", lo, busy);
    else npass++;
    @(negedge clk);
    start = 1'b0;
    ntotal++;
    if (lo !== 32'h55) $display("FAIL idle_start_accepted got lo=%h want 00000055", lo);
    else npass++;
    run_op(OP_MULTU, 32'd2, 32'd3, cyc);
    ntotal++;
    if (lo !== 32'd6 || hi !== 32'd0 || cyc !== 34) $display("FAIL back_to_back got hi=%h lo=%h cyc=%0d want 0 6 34", hi, lo, cyc);
    else npass++;
    @(negedge clk);
  endtask
  task automatic test_ignore_busy;
    int cyc = 1;
    issue(OP_MULTU, 32'd6, 32'd7);
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == 10) begin start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9; end
      if (cyc == 11) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    ntotal++;
    if (cyc !== 34 || hi !== 32'd0 || lo !== 32'd42) $display("FAIL busy_start_ignored got cyc=%0d hi=%h lo=%h want 34 0 0000002a", cyc, hi, lo);
    else npass++;
    @(negedge clk);
  endtask
  task automatic test_abort;
    int dones = 0;
    issue(OP_MTHI, 32'hDEAD, 32'd0);
    issue(OP_MTLO, 32'h77, 32'd0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 1; c <= 20; c++) begin
      if (c == 10) begin start = 1'b1; op = OP_MTLO; a = 32'h1111; end
      if (c == 11) begin
        start = 1'b0;
        ntotal++;
        if (hi !== 32'hDEAD || lo !== 32'h77 || busy !== 1'b1) $display("FAIL abort_start_ignored got hi=%h lo=%h busy=%b want 0000dead 00000077 1", hi, lo, busy);
        else npass++;
      end
      if (c == 20) reset = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    ntotal++;
    if ({busy, done, hi, lo} !== 66'd0) $display("FAIL abort_reset got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
    else npass++;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    ntotal++;
    if (dones !== 0) $display("FAIL abort_no_done got %0d active cycles want 0", dones);
    else npass++;
  endtask
  initial begin
    test_reset;
    test_multu;
    test_madd_msub;
    test_div;
    test_div0;
    test_move;
    test_back_to_back;
    test_ignore_busy;
    test_abort;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
